decay_scheduler: RTL and testbench
==================================

DECAY_SCHEDULER -- requirements
Module: decay_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 16: number of neuron potential slots swept per timestep.
REQ-002 Parameter ADDR_W, default 4: width of the neuron address; SHALL satisfy 2**ADDR_W >= NUM_NEURONS.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 timestep  input  1  one-cycle pulse requesting a decay sweep.
REQ-006 decay_rate  input  4  rate code (0001, 0010, 0100, 1000, 0011); latched at sweep start.
REQ-007 mem_rd_en  output  1  potential-memory read strobe.
REQ-008 mem_addr  output  ADDR_W  neuron address for read and write.
REQ-009 mem_rd_data  input  32  IEEE-754 single potential; valid the cycle after mem_rd_en.
REQ-010 mem_wr_en  output  1  potential-memory write strobe.
REQ-011 mem_wr_data  output  32  decayed potential to write back.
REQ-012 dec_req  output  1  request to the shared decay unit.
REQ-013 dec_potential  output  32  operand to the decay unit.
REQ-014 dec_rate  output  4  latched rate code to the decay unit.
REQ-015 dec_ack  input  1  decay unit result valid.
REQ-016 dec_result  input  32  decayed potential from the decay unit.
REQ-017 busy  output  1  high from sweep start until the DONE state is exited.
REQ-018 done  output  1  one-cycle pulse at sweep completion.
REQ-019 overrun  output  1  one-cycle pulse when timestep arrives while busy.

Function
REQ-020 FSM states: IDLE, READ, WAIT_RD, DISPATCH, WAIT_ACK, WRITE, DONE.
REQ-021 IDLE with timestep=1: latch decay_rate, clear the index to 0, go to READ next cycle.
REQ-022 READ: mem_rd_en=1 and mem_addr=index for exactly one cycle; go to WAIT_RD.
REQ-023 WAIT_RD: capture mem_rd_data into the operand register; go to DISPATCH (or WRITE under REQ-034).
REQ-024 DISPATCH: assert dec_req with dec_potential=operand and dec_rate=latched rate; go to WAIT_ACK.
REQ-025 WAIT_ACK: hold dec_req and operands stable until dec_ack=1 is sampled, then capture dec_result and go to WRITE. A dec_ack present in the first WAIT_ACK cycle SHALL be accepted. Wait is unbounded.
REQ-026 dec_ack outside WAIT_ACK SHALL be ignored.
REQ-027 WRITE: mem_wr_en=1, mem_addr=index, mem_wr_data=result for exactly one cycle. If index==NUM_NEURONS-1 go to DONE; otherwise increment index and go to READ.
REQ-028 DONE: done=1 for one cycle; return to IDLE. A timestep in DONE SHALL be treated as overrun.
REQ-029 Minimum sweep latency with zero-wait ack: 5 cycles per neuron plus 1 DONE cycle. timestep at cycle T yields done at T+1+5*NUM_NEURONS.
REQ-030 timestep while busy: sweep unaffected, overrun pulses the following cycle, request discarded (not queued).
REQ-031 The scheduler performs no arithmetic on potentials except the REQ-034 check; an unsupported rate code SHALL be forwarded unchanged.
REQ-032 Strobes mem_rd_en, mem_wr_en and dec_req SHALL never be high in the same cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, index=0, and all outputs to 0 (including mem_wr_en mid-WRITE and dec_req mid-handshake). The sweep is abandoned and does not resume; done SHALL NOT pulse.

Configuration
REQ-034 Macro UNDERFLOW_FLUSH_EN: when defined, the WAIT_RD state computes shift (0010->1, 0100->2, 1000->3, 0011->2, other->0). If shift>0 and the operand exponent field [30:23] <= shift, the state skips DISPATCH/WAIT_ACK and goes directly to WRITE with mem_wr_data=32'h00000000. When undefined, every neuron is dispatched and the written value is exactly dec_result.

Verification
REQ-035 NUM_NEURONS=4, slot0=32'h41deb852, rate 0010, decay model acks next cycle with 0x415eb852 -> slot0 written 0x415eb852, done at T+21, busy high T+1..T+21.
REQ-036 Decay model delays ack 7 cycles on neuron 2 -> dec_req and dec_potential stable throughout, no mem strobe during the wait, correct write-back.
REQ-037 timestep re-pulsed at T+5 -> overrun at T+6, single done, no second sweep.
REQ-038 rst_n low during WRITE of neuron 1 -> mem_wr_en falls asynchronously, no done; a new timestep restarts at neuron 0.
REQ-039 UNDERFLOW_FLUSH_EN defined, slot=32'h00800000, rate 1000 -> no dec_req for that neuron, slot written 0; macro undefined -> dispatched normally.
REQ-040 Every cycle: check the REQ-032 strobe exclusivity and that done pulses exactly once per accepted timestep.

Source files
------------

// File: rtl/decay_scheduler.sv
// decay_scheduler: sweeps every neuron potential through the shared decay unit once per timestep.
// Optional feature macro UNDERFLOW_FLUSH_EN: potentials whose exponent would underflow are written
// back as zero without being dispatched to the decay unit.
module decay_scheduler #(
   parameter int NUM_NEURONS = 16,
   parameter int ADDR_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              timestep,
   input  logic [3:0]        decay_rate,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rd_data,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wr_data,
   output logic              dec_req,
   output logic [31:0]       dec_potential,
   output logic [3:0]        dec_rate,
   input  logic              dec_ack,
   input  logic [31:0]       dec_result,
   output logic              busy,
   output logic              done,
   output logic              overrun
);
   typedef enum logic [2:0] {IDLE, READ, WAIT_RD, DISPATCH, WAIT_ACK, WRITE, DONE} state_t;
   state_t st, nxt;
   logic [ADDR_W-1:0] idx;
   logic [3:0] rate;
   logic [31:0] operand, result;
   logic last, flush;
   assign last = idx == ADDR_W'(NUM_NEURONS - 1);
`ifdef UNDERFLOW_FLUSH_EN
   logic [7:0] shift;
   // exponent decrement implied by the latched rate; an exponent at or below it cannot survive decay
   always_comb shift = rate == 4'b0010 ? 8'd1 :
                       rate == 4'b0100 ? 8'd2 :
                       rate == 4'b1000 ? 8'd3 :
                       rate == 4'b0011 ? 8'd2 : 8'd0;
   assign flush = shift != 8'd0 && mem_rd_data[30:23] <= shift;
`else
   assign flush = 1'b0;
`endif
   // state register; reset abandons any sweep in progress
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else st <= nxt;
   // sweep sequencing: one neuron at a time, waiting indefinitely on the decay unit
   always_comb begin
      nxt = st;
      case (st)
         IDLE:     nxt = timestep ? READ : IDLE;
         READ:     nxt = WAIT_RD;
         WAIT_RD:  nxt = flush ? WRITE : DISPATCH;
         DISPATCH: nxt = WAIT_ACK;
         WAIT_ACK: nxt = dec_ack ? WRITE : WAIT_ACK;
         WRITE:    nxt = last ? DONE : READ;
         DONE:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end
   // datapath: rate latch, neuron index, operand/result capture and the overrun flag
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx     <= '0;
         rate    <= '0;
         operand <= '0;
         result  <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= timestep && st != IDLE;
         if (st == IDLE && timestep) begin
            rate <= decay_rate;
            idx  <= '0;
         end
         if (st == WAIT_RD) operand <= mem_rd_data;
         if (st == WAIT_RD && flush) result <= '0;
         if (st == WAIT_ACK && dec_ack) result <= dec_result;
         if (st == WRITE && !last) idx <= idx + 1'b1;
      end
   // outputs decode from state only, so reset clears them without waiting for a clock
   always_comb begin
      mem_rd_en     = st == READ;
      mem_wr_en     = st == WRITE;
      dec_req       = st == DISPATCH || st == WAIT_ACK;
      mem_addr      = (mem_rd_en || mem_wr_en) ? idx : '0;
      mem_wr_data   = mem_wr_en ? result : '0;
      dec_potential = dec_req ? operand : '0;
      dec_rate      = dec_req ? rate : '0;
      busy          = st != IDLE;
      done          = st == DONE;
   end
endmodule

// File: tb/tb_decay_scheduler.sv
// tb_decay_scheduler: directed and randomized sweeps against a slot-level reference of the decay sweep.
module tb_decay_scheduler;
   localparam int N = 4;
`ifdef UNDERFLOW_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif
   logic clk = 0, rst_n = 0, timestep = 0;
   logic [3:0] decay_rate = '0;
   logic mem_rd_en, mem_wr_en, dec_req, dec_ack, busy, done, overrun;
   logic [1:0] mem_addr;
   logic [31:0] mem_rd_data, mem_wr_data, dec_potential, dec_result;
   logic [3:0] dec_rate;
   int checks = 0, errors = 0, cyc = 0;
   logic [31:0] mem [N];
   logic [31:0] snap [N];
   bit dispatched [N];
   int dly [N];
   logic ld = 0;
   int ld_a = 0;
   logic [31:0] ld_d = '0;
   logic [3:0] cur_rate = '0;
   int rcount = 0, wcount = 0, done_cnt = 0, done_cyc = 0, ovr_cnt = 0, ovr_cyc = 0, t0 = 0, exp_len = 0;
   bit prev_req = 0;
   logic [31:0] prev_pot = '0;
   int cnt = 0;
   logic real_ack;
   bit spur = 0;
   logic [3:0] rates [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110};

   decay_scheduler #(.NUM_NEURONS(N), .ADDR_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .timestep(timestep), .decay_rate(decay_rate),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .dec_req(dec_req), .dec_potential(dec_potential), .dec_rate(dec_rate),
      .dec_ack(dec_ack), .dec_result(dec_result),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int shift_of(logic [3:0] r);
      case (r)
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         4'b0011: return 2;
         default: return 0;
      endcase
   endfunction
   function automatic logic [31:0] ref_decay(logic [31:0] p, logic [3:0] r);
      return p - (32'(shift_of(r)) << 23);
   endfunction
   function automatic bit flushes(logic [31:0] p, logic [3:0] r);
      return FLUSH && shift_of(r) > 0 && int'(p[30:23]) <= shift_of(r);
   endfunction
   function automatic logic [31:0] exp_word(int i);
      return flushes(snap[i], cur_rate) ? 32'h0 : ref_decay(snap[i], cur_rate);
   endfunction

   // potential memory: one-cycle read latency, testbench preload port
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      else if (ld) mem[ld_a] <= ld_d;
   end
   // decay unit: acks after dly[neuron] cycles of request; optional stray acks elsewhere
   always @(posedge clk) cnt <= (dec_req && !real_ack) ? cnt + 1 : 0;
   always_comb begin
      real_ack = dec_req && cnt == dly[wcount];
      dec_ack = real_ack || (spur && !(dec_req && cnt > 0));
      dec_result = real_ack ? ref_decay(dec_potential, dec_rate) : 32'hDEADBEEF;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("strobe_excl", 32'(int'(mem_rd_en) + int'(mem_wr_en) + int'(dec_req) <= 1), 1);
      if (dec_req) begin
         check("dec_pot", dec_potential, snap[wcount]);
         check("dec_rate", 32'(dec_rate), 32'(cur_rate));
         if (prev_req) check("dec_hold", dec_potential, prev_pot);
         dispatched[wcount] = 1;
      end
      prev_req = dec_req;
      prev_pot = dec_potential;
      if (mem_rd_en) begin
         check("rd_addr", 32'(mem_addr), rcount);
         rcount++;
      end
      if (mem_wr_en) begin
         check("wr_addr", 32'(mem_addr), wcount);
         check("wr_data", mem_wr_data, exp_word(wcount));
         check("dispatch", 32'(dispatched[wcount]), 32'(!flushes(snap[wcount], cur_rate)));
         wcount++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (overrun) begin
         ovr_cnt++;
         ovr_cyc = cyc;
      end
   endtask

   task automatic load(input int i, input logic [31:0] v);
      ld = 1;
      ld_a = i;
      ld_d = v;
      tick();
      ld = 0;
   endtask

   task automatic launch(input logic [3:0] r);
      exp_len = 0;
      for (int i = 0; i < N; i++) begin
         snap[i] = mem[i];
         dispatched[i] = 0;
         exp_len += flushes(snap[i], r) ? 3 : 4 + dly[i];
      end
      cur_rate = r;
      rcount = 0;
      wcount = 0;
      done_cnt = 0;
      ovr_cnt = 0;
      decay_rate = r;
      timestep = 1;
      t0 = cyc;
      tick();
      timestep = 0;
      decay_rate = 4'($urandom);
      check("launch_busy", 32'(busy), 1);
   endtask

   // ovr_at: cycle offset of a stray timestep, -1 none, -2 during the DONE cycle
   task automatic sweep(input string tag, input logic [3:0] r, input int ovr_at);
      int oa;
      launch(r);
      oa = ovr_at == -2 ? exp_len + 1 : ovr_at;
      while (done_cnt == 0 && cyc - t0 <= exp_len + 30) begin
         timestep = (cyc - t0 == oa);
         tick();
         timestep = 0;
         if (cyc - t0 <= exp_len + 1) check({tag, "_busy"}, 32'(busy), 1);
      end
      timestep = (cyc - t0 == oa);
      tick();
      timestep = 0;
      check({tag, "_idle"}, 32'(busy), 0);
      check({tag, "_done_lat"}, done_cyc - t0, 1 + exp_len);
      if (ovr_at != -1) check({tag, "_ovr_cyc"}, ovr_cyc - t0, oa + 1);
      check({tag, "_ovr_cnt"}, ovr_cnt, ovr_at != -1 ? 1 : 0);
      repeat (3) tick();
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_reads"}, rcount, N);
      check({tag, "_writes"}, wcount, N);
      for (int i = 0; i < N; i++) check($sformatf("%s_slot%0d", tag, i), mem[i], exp_word(i));
   endtask

   initial begin
      for (int i = 0; i < N; i++) dly[i] = 1;
      #1;
      check("rst_strobes", {29'b0, mem_rd_en, mem_wr_en, dec_req}, 0);
      check("rst_status", {29'b0, busy, done, overrun}, 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", mem_wr_data, 0);
      check("rst_pot", dec_potential, 0);
      check("rst_rate", 32'(dec_rate), 0);
      tick();
      tick();
      rst_n = 1;
      load(0, 32'h41deb852);
      for (int i = 1; i < N; i++) load(i, $urandom);
      sweep("req035", 4'b0010, -1);
      check("req035_lat", done_cyc - t0, 21);
      check("req035_slot0", mem[0], 32'h415eb852);
      dly[2] = 7;
      sweep("req036", 4'b0100, -1);
      dly[2] = 1;
      sweep("req037", 4'b1000, 5);
      sweep("ovr_done", 4'b0011, -2);
      spur = 1;
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 4);
      sweep("spur_ack", 4'b0010, -1);
      spur = 0;
      for (int i = 0; i < N; i++) dly[i] = 1;
      sweep("unsupported", 4'b0101, -1);
      for (int i = 0; i < N; i++) load(i, $urandom);
      launch(4'b0010);
      for (int k = 0; k < 40 && wcount < 2; k++) tick();
      check("req038_in_write", 32'(mem_wr_en), 1);
      #1 rst_n = 0;
      #1;
      check("req038_wr_low", 32'(mem_wr_en), 0);
      check("req038_busy_low", 32'(busy), 0);
      check("req038_outs", mem_wr_data | 32'(mem_addr) | dec_potential, 0);
      tick();
      tick();
      rst_n = 1;
      tick();
      check("req038_no_done", done_cnt, 0);
      check("req038_slot0", mem[0], exp_word(0));
      check("req038_slot1", mem[1], snap[1]);
      sweep("restart", 4'b0100, -1);
      load(1, 32'h00800000);
      sweep("req039", 4'b1000, -1);
      check("req039_slot", mem[1], FLUSH ? 32'h0 : 32'hFF000000);
      check("req039_disp", 32'(dispatched[1]), FLUSH ? 0 : 1);
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < N; i++) begin
            logic [31:0] v;
            v = $urandom;
            if ($urandom_range(0, 2) == 0) v[30:23] = 8'($urandom_range(0, 4));
            load(i, v);
            dly[i] = $urandom_range(1, 4);
         end
         spur = 1'($urandom_range(0, 1));
         sweep($sformatf("rand%0d", s), rates[$urandom_range(0, 5)], $urandom_range(0, 1) == 1 ? int'($urandom_range(2, 10)) : -1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
